// File: rtl/spi_master_tx.sv
// spi_master_tx: vgaclk-domain full-duplex SPI master, MSB first, sck idle low, WIDTH-bit frames.
// Define SPI_CSN_EN to add an active-low chip select output (cs_n).
module spi_master_tx #(
    parameter int WIDTH = 32,
    parameter int DIV   = 4
) (
    input  logic             vgaclk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi
`ifdef SPI_CSN_EN
    ,
    output logic             cs_n
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] txShift_q;
    logic [WIDTH-1:0] rxShift_q;
    logic [WIDTH-1:0] rxData_q;
    logic [CW-1:0]    bitCnt_q;
    logic [DW-1:0]    divCnt_q;
    logic             sck_q;
    logic             sdo_q;
    logic             busy_q;
    logic             done_q;
`ifdef SPI_CSN_EN
    logic             csN_q;
`endif

    logic divLast;
    assign divLast = (divCnt_q == DW'(DIV - 1));

    // SETUP, HIGH and LOW each last DIV cycles; the phase ends when divCnt_q wraps.
    // sdi is captured as sck falls, and sdo only moves as sck rises so it is
    // stable across the falling edge the slave samples on.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            txShift_q <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            bitCnt_q  <= '0;
            divCnt_q  <= '0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_CSN_EN
            csN_q     <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        txShift_q <= tx_data;
                        sdo_q     <= tx_data[WIDTH-1];
                        bitCnt_q  <= '0;
                        divCnt_q  <= '0;
                        sck_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
`ifdef SPI_CSN_EN
                        csN_q     <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    if (divLast) begin
                        divCnt_q <= '0;
                        sck_q    <= 1'b1;
                        state_q  <= HIGH;
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (divLast) begin
                        divCnt_q  <= '0;
                        sck_q     <= 1'b0;
                        rxShift_q <= {rxShift_q[WIDTH-2:0], sdi};
                        bitCnt_q  <= bitCnt_q + 1'b1;
                        state_q   <= LOW;
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                LOW: begin
                    if (divLast) begin
                        divCnt_q <= '0;
                        if (bitCnt_q == CW'(WIDTH)) begin
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            rxData_q <= rxShift_q;
                            sck_q    <= 1'b0;
                            sdo_q    <= 1'b0;
                            state_q  <= DONE;
`ifdef SPI_CSN_EN
                            csN_q    <= 1'b1;
`endif
                        end else begin
                            sck_q     <= 1'b1;
                            txShift_q <= txShift_q << 1;
                            sdo_q     <= txShift_q[WIDTH-2];
                            state_q   <= HIGH;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rxData_q;
    assign sck     = sck_q;
    assign sdo     = sdo_q;
`ifdef SPI_CSN_EN
    assign cs_n    = csN_q;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: scoreboard bench for spi_master_tx with loopback and a model SPI slave.
// Defining SPI_CSN_EN switches to DIV=1 and adds chip-select checks.
module tb_spi_master_tx;

    localparam int WIDTH = 32;
`ifdef SPI_CSN_EN
    localparam int DIV = 1;
`else
    localparam int DIV = 4;
`endif
    localparam int LATENCY       = 1 + (2 * WIDTH + 1) * DIV;
    localparam int RESET_EDGE    = (LATENCY > 200) ? 100 : LATENCY / 2;
    localparam int MIDSTART_EDGE = (LATENCY > 100) ? 50 : LATENCY / 3;

    logic             vgaclk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sck;
    logic             sdo;
    logic             sdi;
`ifdef SPI_CSN_EN
    logic             cs_n;
`endif

    logic        loopback    = 1'b1;
    logic        slaveReload = 1'b0;
    logic [31:0] slaveWordIn = 32'h0;
    logic [31:0] slaveTx     = 32'h0;
    logic [31:0] slaveRx     = 32'h0;

    int cyc         = 0;
    int sckRises    = 0;
    int sckBase     = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rxExp;
        logic [31:0] slaveExp;
        int          doneCyc;
    } exp_t;

    exp_t sb[$];

    spi_master_tx #(
        .WIDTH(WIDTH),
        .DIV  (DIV)
    ) dut (
        .vgaclk (vgaclk),
        .reset  (reset),
        .start  (start),
        .tx_data(tx_data),
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data),
        .sck    (sck),
        .sdo    (sdo),
        .sdi    (sdi)
`ifdef SPI_CSN_EN
        ,
        .cs_n   (cs_n)
`endif
    );

    always #5 vgaclk = ~vgaclk;

    always @(posedge vgaclk) cyc <= cyc + 1;

    always @(posedge sck) sckRises++;

    // Model slave: presents its MSB ahead of the first falling edge, then on each
    // falling sck edge captures sdo and rotates the next bit of its word onto sdi.
    always @(negedge sck or posedge slaveReload) begin
        if (slaveReload) begin
            slaveTx = slaveWordIn;
        end else begin
            slaveRx = {slaveRx[30:0], sdo};
            slaveTx = {slaveTx[30:0], slaveTx[31]};
        end
    end

    assign sdi = loopback ? sdo : slaveTx[31];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest scoreboard entry.
    always @(negedge vgaclk) begin
        exp_t e;
        if (reset) begin
            sckBase = sckRises;
        end else if (done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious done", done, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rx_data", rx_data, e.rxExp);
                checkOutput("done edge", cyc, e.doneCyc);
                checkOutput("slave rx", slaveRx, e.slaveExp);
                checkOutput("sck rises", sckRises - sckBase, WIDTH);
                checkOutput("busy at done", busy, 0);
                checkOutput("sck at done", sck, 0);
                checkOutput("sdo at done", sdo, 0);
`ifdef SPI_CSN_EN
                checkOutput("cs_n at done", cs_n, 1);
`endif
            end
            sckBase = sckRises;
        end
    end

    task automatic pushExp(input logic [31:0] rxExp, input logic [31:0] slaveExp, input int doneCyc);
        exp_t e;
        e.rxExp    = rxExp;
        e.slaveExp = slaveExp;
        e.doneCyc  = doneCyc;
        sb.push_back(e);
    endtask

    task automatic loadSlave(input logic lb, input logic [31:0] word);
        loopback    = lb;
        slaveWordIn = word;
        slaveReload = 1'b1;
        #1;
        slaveReload = 1'b0;
    endtask

    // Pulses start for one cycle; t0 is the edge after which start was raised.
    task automatic applyStimulus(input logic [31:0] txWord, input logic lb,
                                 input logic [31:0] slaveWord, output int t0);
        loadSlave(lb, slaveWord);
        tx_data = txWord;
        @(posedge vgaclk);
        #1;
        start = 1'b1;
        t0    = cyc;
        pushExp(lb ? txWord : slaveWord, txWord, t0 + LATENCY);
        @(posedge vgaclk);
        #1;
        start = 1'b0;
        checkOutput("busy at edge 1", busy, 1);
        checkOutput("sck at edge 1", sck, 0);
        checkOutput("sdo at edge 1", sdo, txWord[31]);
`ifdef SPI_CSN_EN
        checkOutput("cs_n at edge 1", cs_n, 0);
`endif
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge vgaclk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("frame timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (8) @(posedge vgaclk);
        #1;
    endtask

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int n;

        reset   = 1'b1;
        start   = 1'b0;
        tx_data = '0;
        repeat (3) @(posedge vgaclk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset sck", sck, 0);
        checkOutput("reset sdo", sdo, 0);
        checkOutput("reset rx_data", rx_data, 0);
`ifdef SPI_CSN_EN
        checkOutput("reset cs_n", cs_n, 1);
`endif
        reset = 1'b0;
        repeat (2) @(posedge vgaclk);
        #1;
`ifdef SPI_CSN_EN
        checkOutput("idle cs_n", cs_n, 1);
`endif

        $display("[TB] loopback frame");
        applyStimulus(32'hA5C30F81, 1'b1, 32'h0, t0);
        waitDone(2 * LATENCY);

        $display("[TB] model slave frame");
        applyStimulus(32'hDEADBEEF, 1'b0, 32'h12345678, t0);
        waitDone(2 * LATENCY);
        checkOutput("rx_data hold", rx_data, 32'h12345678);

        $display("[TB] start held high");
        loadSlave(1'b1, 32'h0);
        tx_data = 32'hFFFF0000;
        @(posedge vgaclk);
        #1;
        start = 1'b1;
        t0    = cyc;
        pushExp(32'hFFFF0000, 32'hFFFF0000, t0 + LATENCY);
        pushExp(32'hFFFF0000, 32'hFFFF0000, t0 + 2 * LATENCY + 1);
        n = 0;
        while (sb.size() != 0 && n < 3 * LATENCY) begin
            @(posedge vgaclk);
            #1;
            n++;
            if (cyc - t0 == LATENCY + 1) checkOutput("idle gap busy", busy, 0);
            if (cyc - t0 == LATENCY + 2) checkOutput("restart busy", busy, 1);
        end
        start = 1'b0;
        waitDone(10);

        $display("[TB] start and tx_data change mid-frame");
        applyStimulus(32'h0000FFFF, 1'b1, 32'h0, t0);
        while (cyc < t0 + MIDSTART_EDGE) begin
            @(posedge vgaclk);
            #1;
        end
        start   = 1'b1;
        tx_data = 32'h0;
        @(posedge vgaclk);
        #1;
        start = 1'b0;
        checkOutput("busy after ignored start", busy, 1);
        waitDone(2 * LATENCY);

        $display("[TB] reset mid-frame");
        applyStimulus(32'hC0FFEE11, 1'b1, 32'h0, t0);
        while (cyc < t0 + RESET_EDGE) begin
            @(posedge vgaclk);
            #1;
        end
        reset = 1'b1;
        sb.delete();
        #1;
        checkOutput("abort sck", sck, 0);
        checkOutput("abort sdo", sdo, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort rx_data", rx_data, 0);
        checkOutput("abort done", done, 0);
`ifdef SPI_CSN_EN
        checkOutput("abort cs_n", cs_n, 1);
`endif
        repeat (2) @(posedge vgaclk);
        #1;
        reset = 1'b0;
        repeat (LATENCY) @(posedge vgaclk);
        #1;
        checkOutput("no done after abort", rx_data, 0);
        applyStimulus(32'h3C3C5A5A, 1'b0, 32'h0F1E2D3C, t0);
        waitDone(2 * LATENCY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
